fft_sdf_ctrl: RTL and testbench

- Sequencing controller for the 32-point radix-2 single-path delay-feedback (SDF) FFT pipeline.
- The pipeline has five butterfly stages. Their feedback shift registers have lengths 16, 8, 4, 2 and 1.
- The block accepts a framed sample stream and generates the per-stage butterfly selects and the twiddle ROM addresses.
- It also drives the zero-insertion used for draining, plus output valid/index tagging and error detection.
- It has no datapath of its own and sits beside the stage chain.

---
 rtl/fft_sdf_ctrl.sv | 125 ++++++++++++
 tb/tb_fft_sdf_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fft_sdf_ctrl.sv
// rtl/fft_sdf_ctrl.sv - sequencing controller for a 32-point radix-2 SDF FFT pipeline

module fft_sdf_ctrl #(
    parameter int LOG2N = 5
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic                           zero_in,
    output logic [LOG2N-1:0]               bf_sel,
    output logic [(LOG2N-1)*(LOG2N-1)-1:0] tw_addr,
    output logic                           out_valid,
    output logic [LOG2N-1:0]               out_idx,
    output logic                           frame_done,
    output logic                           busy,
    output logic                           err
);
    localparam int N   = 1 << LOG2N;
    localparam int LAT = N - 1;
    localparam int TWW = LOG2N - 1;

    typedef logic [LOG2N-1:0] cnt_t;
    typedef logic [TWW-1:0]   tw_t;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

    state_t           state_q, state_d;
    cnt_t             g_q, g_d;
    cnt_t             fcnt_q, fcnt_d;
    logic [LAT-1:0]   vline_q, vline_d;
    logic             err_q, err_d;
    logic             in_acc;
    logic             active;
    cnt_t             op;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            g_q     <= '0;
            fcnt_q  <= '0;
            vline_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            fcnt_q  <= fcnt_d;
            vline_q <= vline_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        fcnt_d  = fcnt_q;
        err_d   = err_q;
        in_acc  = in_valid && (state_q != S_FLUSH);
        vline_d = {vline_q[LAT-2:0], in_acc};
        case (state_q)
            S_IDLE: begin
                g_d = '0;
                if (in_valid) begin
                    state_d = S_RUN;
                    g_d     = cnt_t'(1);
                    err_d   = 1'b0;
                end
            end
            S_RUN: begin
                g_d = g_q + cnt_t'(1);
                if (!in_valid) begin
                    state_d = S_FLUSH;
                    // A g=0 gap ends a completed frame; that cycle already counts as the first drain cycle.
                    if (g_q == '0) begin
                        fcnt_d = cnt_t'(1);
                    end else begin
                        fcnt_d  = '0;
                        err_d   = 1'b1;
                        vline_d = '0;
                    end
                end
            end
            S_FLUSH: begin
                g_d    = g_q + cnt_t'(1);
                fcnt_d = fcnt_q + cnt_t'(1);
                if (fcnt_q == cnt_t'(LAT - 1)) begin
                    state_d = S_IDLE;
                    g_d     = '0;
                    fcnt_d  = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                g_d     = '0;
                fcnt_d  = '0;
            end
        endcase
    end

    assign active     = (state_q != S_IDLE);
    assign in_ready   = (state_q != S_FLUSH);
    assign zero_in    = (state_q != S_RUN);
    assign busy       = active;
    assign err        = err_q;
    assign out_valid  = vline_q[LAT-1];
    assign op         = g_q + cnt_t'(1);
    assign out_idx    = out_valid ? {<<{op}} : '0;
    assign frame_done = out_valid && (op == '1);

    for (genvar s = 0; s < LOG2N; s++) begin : g_bf
        localparam cnt_t OFF = cnt_t'(N - (N >> s));
        localparam cnt_t SEL = cnt_t'(1) << (LOG2N - 1 - s);
        assign bf_sel[s] = active && (((g_q - OFF) & SEL) != '0);
    end

    // Twiddle phase trails the butterfly select by one shift-register length.
    for (genvar s = 0; s < LOG2N - 1; s++) begin : g_tw
        localparam cnt_t POFF = cnt_t'(N - (N >> s) + (N >> (s + 1)));
        localparam cnt_t MASK = cnt_t'((N >> (s + 1)) - 1);
        localparam cnt_t SEL  = cnt_t'(1) << (LOG2N - 1 - s);
        cnt_t p;
        assign p = g_q - POFF;
        assign tw_addr[TWW*s +: TWW] = (active && ((p & SEL) != '0)) ? tw_t'((p & MASK) << s) : '0;
    end

endmodule

// File: tb/tb_fft_sdf_ctrl.sv
// tb/tb_fft_sdf_ctrl.sv - self-checking bench for fft_sdf_ctrl

module tb_fft_sdf_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready, zero_in, out_valid, frame_done, busy, err;
    logic [4:0]  bf_sel, out_idx;
    logic [15:0] tw_addr;

    int total = 0;
    int bad   = 0;

    fft_sdf_ctrl #(.LOG2N(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .in_ready(in_ready), .zero_in(zero_in), .bf_sel(bf_sel), .tw_addr(tw_addr),
        .out_valid(out_valid), .out_idx(out_idx), .frame_done(frame_done),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: mode 0=idle 1=run 2=flush; vt[c]=1 means an output is due at cycle c.
    int m_mode = 0, m_g = 0, m_rem = 0, m_err = 0, cyc = 0;
    bit started = 0;
    bit vt [0:4095];
    int off [5] = '{0, 16, 24, 28, 30};
    int op, e_bf, e_tw, e_idx, p, dd;
    bit ov;

    always @(negedge clk) begin
        if (started) begin
            op = (m_g + 1) % 32;
            ov = vt[cyc];
            e_bf = 0;
            e_tw = 0;
            e_idx = 0;
            if (m_mode != 0) begin
                for (int s = 0; s < 5; s++) begin
                    e_bf |= ((((m_g - off[s] + 32) % 32) >> (4 - s)) & 1) << s;
                    if (s < 4) begin
                        dd = 16 >> s;
                        p = (m_g - off[s] - dd + 64) % 32;
                        if (((p >> (4 - s)) & 1) == 1)
                            e_tw |= (((p % dd) << s) & 15) << (4 * s);
                    end
                end
            end
            if (ov)
                for (int i = 0; i < 5; i++) e_idx |= ((op >> i) & 1) << (4 - i);
            chk("in_ready", in_ready, m_mode != 2);
            chk("zero_in", zero_in, m_mode != 1);
            chk("busy", busy, m_mode != 0);
            chk("err", err, m_err);
            chk("bf_sel", bf_sel, e_bf);
            chk("tw_addr", tw_addr, e_tw);
            chk("out_valid", out_valid, ov);
            chk("out_idx", out_idx, e_idx);
            chk("frame_done", frame_done, ov && op == 31);
        end
        if (!rst) begin
            m_mode = 0; m_g = 0; m_err = 0; m_rem = 0;
            for (int i = 1; i <= 31; i++) vt[cyc + i] = 0;
        end else begin
            case (m_mode)
                0: if (in_valid) begin
                    vt[cyc + 31] = 1; m_err = 0; m_mode = 1; m_g = 1;
                end
                1: begin
                    if (in_valid) begin
                        vt[cyc + 31] = 1;
                    end else begin
                        if (m_g == 0) m_rem = 30;
                        else begin
                            m_rem = 31; m_err = 1;
                            for (int i = 1; i <= 31; i++) vt[cyc + i] = 0;
                        end
                        m_mode = 2;
                    end
                    m_g = (m_g + 1) % 32;
                end
                default: begin
                    m_rem--;
                    if (m_rem == 0) begin m_mode = 0; m_g = 0; end
                    else m_g = (m_g + 1) % 32;
                end
            endcase
        end
        started = 1;
        cyc++;
    end

    task automatic tick(input bit r, input bit v);
        @(posedge clk);
        #1;
        rst = r;
        in_valid = v;
    endtask

    int ov_cnt, fd_cnt, z_cnt;
    int fd_pos [3];

    initial begin
        rst = 1'b0;
        in_valid = 1'b0;

        // reset then idle
        for (int k = 0; k < 3; k++) tick(0, 0);
        for (int k = 0; k < 5; k++) begin
            tick(1, 0);
            chk("idle_ready", in_ready, 1);
            chk("idle_zero", zero_in, 1);
            chk("idle_busy", busy, 0);
            chk("idle_ov", out_valid, 0);
            chk("idle_err", err, 0);
        end

        // single frame
        for (int k = 0; k < 72; k++) begin
            tick(1, k < 32);
            case (k)
                15: chk("bf0_k15", bf_sel[0], 0);
                16: chk("bf0_k16", bf_sel[0], 1);
                30: chk("ov_k30", out_valid, 0);
                31: begin
                    chk("ov_k31", out_valid, 1);
                    chk("idx_k31", out_idx, 0);
                    chk("bf0_k31", bf_sel[0], 1);
                    chk("bf4_k31", bf_sel[4], 1);
                end
                32: begin
                    chk("idx_k32", out_idx, 16);
                    chk("bf0_k32", bf_sel[0], 0);
                    chk("bf4_k32", bf_sel[4], 0);
                    chk("tw0_k32", tw_addr[3:0], 0);
                    chk("ready_k32", in_ready, 1);
                end
                33: begin
                    chk("idx_k33", out_idx, 8);
                    chk("zero_k33", zero_in, 1);
                    chk("ready_k33", in_ready, 0);
                end
                39: chk("tw_k39", tw_addr, 16'h00E7);
                47: chk("tw0_k47", tw_addr[3:0], 15);
                62: begin
                    chk("fd_k62", frame_done, 1);
                    chk("idx_k62", out_idx, 31);
                    chk("busy_k62", busy, 1);
                end
                63: begin
                    chk("busy_k63", busy, 0);
                    chk("ov_k63", out_valid, 0);
                    chk("ready_k63", in_ready, 1);
                end
                default: ;
            endcase
        end

        // three back-to-back frames
        ov_cnt = 0; fd_cnt = 0; z_cnt = 0;
        for (int k = 0; k < 166; k++) begin
            tick(1, k < 96);
            if (out_valid) ov_cnt++;
            if (k > 0 && k < 96 && zero_in) z_cnt++;
            if (frame_done) begin
                if (fd_cnt < 3) fd_pos[fd_cnt] = k;
                fd_cnt++;
            end
        end
        chk("b2b_ov_cnt", ov_cnt, 96);
        chk("b2b_fd_cnt", fd_cnt, 3);
        chk("b2b_zero_cnt", z_cnt, 0);
        chk("b2b_fd0", fd_pos[0], 62);
        chk("b2b_fd_gap1", fd_pos[1] - fd_pos[0], 32);
        chk("b2b_fd_gap2", fd_pos[2] - fd_pos[1], 32);

        // mid-frame gap at g=12 of frame 2
        ov_cnt = 0;
        for (int k = 0; k < 81; k++) begin
            tick(1, k < 44);
            if (k >= 45 && out_valid) ov_cnt++;
            case (k)
                44: begin
                    chk("gap_ov_k44", out_valid, 1);
                    chk("gap_err_k44", err, 0);
                end
                45: begin
                    chk("gap_err_k45", err, 1);
                    chk("gap_ov_k45", out_valid, 0);
                    chk("gap_ready_k45", in_ready, 0);
                end
                75: chk("gap_busy_k75", busy, 1);
                76: begin
                    chk("gap_busy_k76", busy, 0);
                    chk("gap_err_k76", err, 1);
                end
                default: ;
            endcase
        end
        chk("gap_ov_after", ov_cnt, 0);
        for (int j = 0; j < 32; j++) begin
            tick(1, 1);
            if (j == 0) chk("err_acc_j0", err, 1);
            if (j == 1) chk("err_acc_j1", err, 0);
        end
        for (int j = 0; j < 40; j++) tick(1, 0);

        // reset at g=20 of frame 2
        ov_cnt = 0;
        for (int k = 0; k < 101; k++) begin
            tick(k != 52, k <= 52);
            if (k > 52 && out_valid) ov_cnt++;
            if (k == 52) chk("rst_ov_k52", out_valid, 1);
            if (k == 53) begin
                chk("rst_busy", busy, 0);
                chk("rst_ready", in_ready, 1);
                chk("rst_zero", zero_in, 1);
                chk("rst_bf", bf_sel, 0);
                chk("rst_tw", tw_addr, 0);
                chk("rst_idx", out_idx, 0);
            end
        end
        chk("rst_ov_after", ov_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
